block_raster_writer: RTL and testbench

BLOCK_RASTER_WRITER -- requirements
Module: block_raster_writer

---
 rtl/block_raster_writer.sv | 118 +++++++++++
 tb/tb_block_raster_writer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_raster_writer.sv
// Block-to-raster frame writer: 8x8 decoded blocks into a raster frame RAM.
// Define BLK_RASTER_ZIGZAG_EN to treat the in-block index as JPEG zigzag order.
module block_raster_writer #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int A     = 17
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic         pix_valid_i,
  input  logic [7:0]   pix_data_i,
  output logic         pix_ready_o,
  output logic         ram_en_o,
  output logic         ram_we_o,
  output logic [A-1:0] ram_addr_o,
  output logic [7:0]   ram_data_o,
  output logic         busy_o,
  output logic         frame_done_o,
  output logic [10:0]  blk_cnt_o
);

  localparam int BW = IMG_W / 8;
  localparam int BH = IMG_H / 8;
  localparam int XW = (BW > 1) ? $clog2(BW) : 1;
  localparam int YW = (BH > 1) ? $clog2(BH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [5:0]    k;
  logic [XW-1:0] bx;
  logic [YW-1:0] by;
  logic          acc;
  logic          blk_end;
  logic          row_end;
  logic          last;
  logic [2:0]    r;
  logic [2:0]    c;
  logic [31:0]   addr;

  assign acc     = pix_ready_o & pix_valid_i;
  assign blk_end = (k == 6'd63);
  assign row_end = (bx == XW'(BW - 1));
  assign last    = blk_end & row_end & (by == YW'(BH - 1));

`ifdef BLK_RASTER_ZIGZAG_EN
  // zigzag index -> natural (raster) position inside the block
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };
  assign {r, c} = ZZ[k];
`else
  assign {r, c} = k;
`endif

  assign addr = (32'(by) * 32'd8 + 32'(r)) * 32'(IMG_W)
              + 32'(bx) * 32'd8 + 32'(c);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      k            <= '0;
      bx           <= '0;
      by           <= '0;
      blk_cnt_o    <= '0;
      pix_ready_o  <= 1'b0;
      busy_o       <= 1'b0;
      ram_en_o     <= 1'b0;
      ram_we_o     <= 1'b0;
      ram_addr_o   <= '0;
      ram_data_o   <= '0;
      frame_done_o <= 1'b0;
    end else begin
      ram_en_o     <= acc;
      ram_we_o     <= acc;
      frame_done_o <= acc & last;
      if (acc) begin
        ram_addr_o <= A'(addr);
        ram_data_o <= pix_data_i;
      end
      unique case (state)
        IDLE: if (start_i) begin
          state       <= RUN;
          k           <= '0;
          bx          <= '0;
          by          <= '0;
          blk_cnt_o   <= '0;
          pix_ready_o <= 1'b1;
          busy_o      <= 1'b1;
        end
        RUN: if (acc) begin
          k <= k + 6'd1;
          if (blk_end) begin
            blk_cnt_o <= blk_cnt_o + 11'd1;
            bx <= row_end ? '0 : bx + XW'(1);
            if (row_end) by <= by + YW'(1);
          end
          if (last) begin
            state       <= DONE;
            pix_ready_o <= 1'b0;
            busy_o      <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_raster_writer.sv
// Bench for block_raster_writer: queued expected writes, negedge monitor.
// Runs a 320x16 frame so the full-frame pass stays short.
module tb_block_raster_writer;

  localparam int W    = 320;
  localparam int H    = 16;
  localparam int NPIX = W * H;
  localparam int NBLK = (W / 8) * (H / 8);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pv = 1'b0;
  logic [7:0]  pd = '0;
  logic        ready, en, we, busy, done;
  logic [16:0] addr;
  logic [7:0]  data;
  logic [10:0] blk;

  always #5 clk = ~clk;

  block_raster_writer #(.IMG_W(W), .IMG_H(H), .A(17)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .pix_valid_i(pv), .pix_data_i(pd), .pix_ready_o(ready),
    .ram_en_o(en), .ram_we_o(we), .ram_addr_o(addr),
    .ram_data_o(data), .busy_o(busy), .frame_done_o(done),
    .blk_cnt_o(blk)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  d;
    logic        f;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   checks = 0;
  int   failures = 0;
  int   wr_cnt[NPIX];
  int   done_pulses = 0;
  int   last_addr = -1;
  int   last_data = -1;
  int   mk, mbx, mby, mblk, sent;
  bit   dead = 0;

`ifdef BLK_RASTER_ZIGZAG_EN
  localparam int ZZ[64] = '{
    0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
  localparam int K2_ADDR = 320;
`else
  localparam int K2_ADDR = 2;
`endif

  function automatic int map_addr(int k, int bx, int by);
    int p;
    p = k;
`ifdef BLK_RASTER_ZIGZAG_EN
    p = ZZ[k];
`endif
    return (by * 8 + p / 8) * W + bx * 8 + p % 8;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_ready"}, 32'(ready), 0);
    chk({tag, "_en"}, 32'(en), 0);
    chk({tag, "_we"}, 32'(we), 0);
    chk({tag, "_addr"}, 32'(addr), 0);
    chk({tag, "_data"}, 32'(data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_blk"}, 32'(blk), 0);
  endtask

  task automatic idle(int n);
    pv = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic begin_frame();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mk = 0; mbx = 0; mby = 0; mblk = 0; sent = 0;
  endtask

  task automatic send(logic [7:0] d);
    int   n;
    logic rdy;
    exp_t e;
    if (dead) return;
    n = 0;
    pv = 1'b1;
    pd = d;
    do begin
      rdy = ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 20);
    chk("ready", 32'(rdy), 1);
    if (rdy) begin
      e.a = 32'(map_addr(mk, mbx, mby));
      e.d = d;
      e.f = (mk == 63 && mbx == W / 8 - 1 && mby == H / 8 - 1);
      q.push_back(e);
      sent++;
      mk++;
      if (mk == 64) begin
        mk = 0;
        mblk++;
        mbx++;
        if (mbx == W / 8) begin
          mbx = 0;
          mby++;
        end
      end
    end else begin
      dead = 1;
    end
    pv = 1'b0;
  endtask

  // write monitor: every queued acceptance must show up one cycle later
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_pulses++;
      if (q.size() > 0) begin
        me = q.pop_front();
        chk("wr_en", 32'(en), 1);
        chk("wr_we", 32'(we), 1);
        if (en) begin
          chk("wr_addr", 32'(addr), me.a);
          chk("wr_data", 32'(data), 32'(me.d));
          chk("wr_done", 32'(done), 32'(me.f));
          if (int'(addr) < NPIX) wr_cnt[addr]++;
          last_addr = int'(addr);
          last_data = int'(data);
        end
      end else if (en || done) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: en=%0d done=%0d addr=%0d required no write",
                 en, done, addr);
      end
    end
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: time expired, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int bad;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    rst_n = 1'b1;
    idle(2);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_ready", 32'(ready), 0);

    begin_frame();
    chk("run_busy", 32'(busy), 1);
    for (int i = 0; i < 64; i++) send(8'(i));
    chk("blk_after_first", 32'(blk), 1);
    send(8'h40);
    @(negedge clk);
    #1;
    chk("blk1_first_addr", 32'(last_addr), 8);

    while (sent < 2560) begin
      if (sent == 1000) begin
        start = 1'b1;
        send(8'(sent * 7 + 3));
        start = 1'b0;
        idle(1);
        chk("blk_after_start", 32'(blk), 32'(mblk));
        chk("busy_after_start", 32'(busy), 1);
      end else begin
        send(8'(sent * 7 + 3));
      end
      if ($urandom_range(0, 3) == 0) idle(1 + $urandom_range(0, 2));
    end
    send(8'hC3);
    @(negedge clk);
    #1;
    chk("blk40_first_addr", 32'(last_addr), 2560);

    while (sent < NPIX && !dead) begin
      send(8'(sent * 7 + 3));
      if ($urandom_range(0, 3) == 0) idle(1 + $urandom_range(0, 2));
    end
    idle(3);
    chk("done_pulses", 32'(done_pulses), 1);
    chk("final_blk", 32'(blk), NBLK);
    chk("final_busy", 32'(busy), 0);
    chk("final_ready", 32'(ready), 0);
    chk("queue_empty", 32'(q.size()), 0);
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (wr_cnt[i] != 1) bad++;
    chk("addr_once_bad", 32'(bad), 0);
    idle(5);
    chk("blk_hold", 32'(blk), NBLK);

    begin_frame();
    chk("restart_blk", 32'(blk), 0);
    for (int i = 0; i < 100; i++) send(8'(i + 1));
    idle(1);
    rst_n = 1'b0;
    #2;
    chk_zero("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pv = 1'b1;
    pd = 8'h77;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    pv = 1'b0;
    chk("postrst_ready", 32'(ready), 0);
    chk("postrst_busy", 32'(busy), 0);

    begin_frame();
    send(8'h5A);
    @(negedge clk);
    #1;
    chk("restart_addr", 32'(last_addr), 0);
    send(8'h11);
    send(8'hAA);
    @(negedge clk);
    #1;
    chk("k2_addr", 32'(last_addr), K2_ADDR);
    chk("k2_data", 32'(last_data), 32'hAA);
    for (int i = 3; i < 64; i++) send(8'(i));
    @(negedge clk);
    #1;
    chk("k63_addr", 32'(last_addr), 2247);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
